sram_row_packer: RTL and testbench
==================================

// Module: sram_row_packer
// PURPOSE
//  Upstream write stage for the 128b x 2048 activation/weight SRAM. Accepts DW-bit words
//  on a valid/ready stream, packs LANES words into one ROW-bit row (lane 0 = LSBs), and issues
//  one single-cycle active-low write (CEN/WEN low, A2 = row pointer) per completed row.
//  Its outputs connect directly to the SRAM D/CEN/WEN/A2 pins. The read side (REN/A1) is not driven here.
// PARAMETERS
//  DW     16    input word width
//  LANES  8     words per row; ROW = DW*LANES = 128, must equal SRAM D width
//  AW     11    SRAM address width
//  DEPTH  2048  rows in SRAM (<= 2**AW)
// PORTS
//  clk           in   1        clock, all state on posedge
//  reset         in   1        asynchronous, active-high
//  in_data       in   DW       input word
//  in_valid      in   1        word present
//  in_ready      out  1        packer accepts; transfer = in_valid & in_ready
//  start         in   1        1-cycle pulse: clear row pointer, lane count, rows_written
//  flush         in   1        1-cycle pulse: zero-pad and write a partial row
//  sram_D        out  ROW      row data to SRAM D
//  sram_CEN      out  1        chip enable to SRAM, active low
//  sram_WEN      out  1        write enable to SRAM, active low
//  sram_A2       out  AW       SRAM write address
//  rows_written  out  AW+1     rows committed since start/reset
//  full          out  1        DEPTH rows written; no further writes
// BEHAVIOUR
//  - Reset (async): state FILL, lane_cnt=0, wr_ptr=0, row buffer=0, sram_D=0, sram_CEN=1,
//    sram_WEN=1, sram_A2=0, rows_written=0, full=0. in_ready=1 once reset deasserts.
//  - States: FILL (collect words) and WRITE (one cycle, SRAM strobe low).
//    in_ready = (state==FILL) & ~full. This is combinational from state and full.
//  - FILL: on each transfer, in_data goes to row[lane_cnt*DW +: DW] and lane_cnt increments.
//    When lane_cnt==LANES-1, the transfer completes the row. Registered outputs load sram_D=row,
//    sram_A2=wr_ptr, CEN=WEN=0. Next state is WRITE and lane_cnt resets to 0.
//  - WRITE: the strobe is low for exactly this cycle. Then CEN=WEN=1, wr_ptr+1, rows_written+1,
//    and the row buffer clears to 0. Return to FILL. Throughput is LANES words per LANES+1 cycles.
//  - The write latency is one cycle from the completing transfer edge to CEN/WEN low.
//    The SRAM captures the row on the following edge.
//  - flush in FILL with lane_cnt>0: the unfilled lanes stay 0, and the row is written as above.
//    flush with lane_cnt==0 is ignored. flush during WRITE is ignored.
//  - flush coincident with a transfer: the word is included first. If that word completes the
//    row, one normal write occurs and no extra write. Otherwise the partial row is written.
//  - start has priority over transfer and flush. In FILL, it discards the partial row and clears
//    wr_ptr, lane_cnt and rows_written. In WRITE, the in-flight write completes at the current
//    wr_ptr, then the counters clear to 0.
//  - full: set when rows_written reaches DEPTH. It blocks in_ready and writes. Cleared only by
//    start or reset.
//  - Strobes are never low for 2 consecutive cycles. sram_D and sram_A2 hold their last value
//    while the strobe is high.
// CONFIGURATION
//  PACKER_WRAP_EN defined: wr_ptr wraps DEPTH-1 -> 0 and writing continues, overwriting the
//    oldest rows. full is tied to 0. rows_written saturates at DEPTH.
//  PACKER_WRAP_EN undefined: no wrap. full asserts after row DEPTH-1 is written and stays
//    high until start.
// TESTING
//  1. Reset, then 8 words 0x0001..0x0008 back-to-back: CEN=WEN=0 for 1 cycle, A2=0,
//     D=0x0008_0007_..._0001. in_ready=0 in that cycle. rows_written=1.
//  2. 3 words 0xAAAA,0xBBBB,0xCCCC, then flush: D=0x...0000_CCCC_BBBB_AAAA (upper 5 lanes 0),
//     A2=next row. flush with 0 words buffered: no strobe.
//  3. The 8th word coincides with flush: exactly one write, with all 8 lanes from data.
//  4. Stream 2048 rows: the last write has A2=2047. full=1, in_ready=0, and no further strobes.
//     With PACKER_WRAP_EN, row 2049 is written at A2=0 and full stays 0.
//  5. start after 5 words: the partial row is discarded. Next 8 words write A2=0. rows_written=1.
//  6. Assert reset mid-row, during WRITE: CEN/WEN=1 immediately (async), and all counters
//     are 0 after release.

Source files
------------

// File: rtl/sram_row_packer.sv
// ============================================================================
// Module      : sram_row_packer
// Description : Packs LANES x DW-bit stream words into ROW-bit SRAM rows and
//               issues one active-low write strobe per completed/flushed row.
//               Optional feature macro: PACKER_WRAP_EN (circular row pointer).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module sram_row_packer #(
    parameter int DW    = 16,
    parameter int LANES = 8,
    parameter int AW    = 11,
    parameter int DEPTH = 2048
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [DW-1:0]         in_data,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic                  start,
    input  logic                  flush,
    output logic [DW*LANES-1:0]   sram_D,
    output logic                  sram_CEN,
    output logic                  sram_WEN,
    output logic [AW-1:0]         sram_A2,
    output logic [AW:0]           rows_written,
    output logic                  full
);

    localparam int ROW = DW * LANES;
    localparam int LW  = (LANES > 1) ? $clog2(LANES) : 1;

    localparam logic [LW-1:0] LAST_LANE = LW'(LANES - 1);
    localparam logic [AW-1:0] LAST_ROW  = AW'(DEPTH - 1);
    localparam logic [AW:0]   DEPTH_CNT = (AW+1)'(DEPTH);

    typedef enum logic [0:0] {
        FILL  = 1'b0,
        WRITE = 1'b1
    } state_t;

    state_t          state, state_n;
    logic [LW-1:0]   lane_cnt, lane_n;
    logic [AW-1:0]   wr_ptr, ptr_n;
    logic [ROW-1:0]  row_buf, row_n;
    logic [ROW-1:0]  d_n;
    logic [AW-1:0]   a_n;
    logic            strobe_n;
    logic [AW:0]     rows_n;
    logic            full_n;
    logic            xfer;
    logic [31:0]     lane_base;

    assign in_ready  = (state == FILL) & ~full;
    assign xfer      = in_valid & in_ready;
    assign lane_base = 32'(lane_cnt) * 32'(DW);

    always_comb begin
        state_n  = state;
        lane_n   = lane_cnt;
        ptr_n    = wr_ptr;
        row_n    = row_buf;
        rows_n   = rows_written;
        full_n   = full;
        d_n      = sram_D;
        a_n      = sram_A2;
        strobe_n = 1'b1;

        case (state)
            FILL: begin
                if (start) begin
                    lane_n = '0;
                    row_n  = '0;
                    ptr_n  = '0;
                    rows_n = '0;
                    full_n = 1'b0;
                end else begin
                    if (xfer) begin
                        row_n[lane_base +: DW] = in_data;
                        lane_n = lane_cnt + 1'b1;
                    end
                    // A coincident word is merged before a flush is considered.
                    if ((xfer && lane_cnt == LAST_LANE) ||
                        (flush && !full && (xfer || lane_cnt != '0))) begin
                        d_n      = row_n;
                        a_n      = wr_ptr;
                        strobe_n = 1'b0;
                        lane_n   = '0;
                        state_n  = WRITE;
                    end
                end
            end

            WRITE: begin
                state_n = FILL;
                row_n   = '0;
                if (start) begin
                    lane_n = '0;
                    ptr_n  = '0;
                    rows_n = '0;
                    full_n = 1'b0;
                end else begin
                    ptr_n = (wr_ptr == LAST_ROW) ? '0 : wr_ptr + 1'b1;
`ifdef PACKER_WRAP_EN
                    rows_n = (rows_written == DEPTH_CNT) ? rows_written
                                                         : rows_written + 1'b1;
                    full_n = 1'b0;
`else
                    rows_n = rows_written + 1'b1;
                    full_n = ((rows_written + 1'b1) == DEPTH_CNT);
`endif
                end
            end

            default: state_n = FILL;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= FILL;
            lane_cnt     <= '0;
            wr_ptr       <= '0;
            row_buf      <= '0;
            rows_written <= '0;
            full         <= 1'b0;
            sram_D       <= '0;
            sram_A2      <= '0;
            sram_CEN     <= 1'b1;
            sram_WEN     <= 1'b1;
        end else begin
            state        <= state_n;
            lane_cnt     <= lane_n;
            wr_ptr       <= ptr_n;
            row_buf      <= row_n;
            rows_written <= rows_n;
            full         <= full_n;
            sram_D       <= d_n;
            sram_A2      <= a_n;
            sram_CEN     <= strobe_n;
            sram_WEN     <= strobe_n;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_sram_row_packer.sv
// ============================================================================
// Module      : tb_sram_row_packer
// Description : Scoreboard bench for sram_row_packer; expected SRAM writes are
//               queued by the stimulus and retired by a negedge monitor.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_sram_row_packer;

    logic          clk;
    logic          reset;
    logic [15:0]   in_data;
    logic          in_valid;
    logic          in_ready;
    logic          start;
    logic          flush;
    logic [127:0]  sram_D;
    logic          sram_CEN;
    logic          sram_WEN;
    logic [10:0]   sram_A2;
    logic [11:0]   rows_written;
    logic          full;

    int tests = 0;
    int fails = 0;

    typedef struct packed {
        logic [10:0]  a;
        logic [127:0] d;
    } exp_t;

    exp_t exp_q[$];
    logic prev_low = 1'b0;

    sram_row_packer dut (
        .clk          (clk),
        .reset        (reset),
        .in_data      (in_data),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .start        (start),
        .flush        (flush),
        .sram_D       (sram_D),
        .sram_CEN     (sram_CEN),
        .sram_WEN     (sram_WEN),
        .sram_A2      (sram_A2),
        .rows_written (rows_written),
        .full         (full)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic expect_write(input logic [10:0] a, input logic [127:0] d);
        exp_t e;
        e.a = a;
        e.d = d;
        exp_q.push_back(e);
    endtask

    task automatic push_word(input logic [15:0] w, input logic fl);
        int waited = 0;
        in_valid = 1'b1;
        in_data  = w;
        flush    = fl;
        while (!in_ready && waited < 20) begin
            @(posedge clk); #1;
            waited++;
        end
        if (!in_ready) begin
            tests++;
            fails++;
            $display("FAIL push_timeout: in_ready got 0, expected 1");
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        flush    = 1'b0;
    endtask

    task automatic push_row(input logic [15:0] base);
        for (int i = 1; i <= 8; i++) push_word(base + 16'(i), 1'b0);
    endtask

    task automatic pulse_flush();
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
    endtask

    // Monitor: every low strobe must match the oldest queued write.
    always @(negedge clk) begin
        if (!reset) begin
            if (sram_CEN === 1'b0) begin
                tests++;
                if (sram_WEN !== 1'b0) begin
                    fails++;
                    $display("FAIL write_wen: got %b, expected 0", sram_WEN);
                end else if (prev_low) begin
                    fails++;
                    $display("FAIL strobe_twice: got low on 2 cycles, expected 1 cycle");
                end else if (exp_q.size() == 0) begin
                    fails++;
                    $display("FAIL unexpected_write: got A2=%0h D=%0h, expected none", sram_A2, sram_D);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    if (sram_A2 !== e.a || sram_D !== e.d) begin
                        fails++;
                        $display("FAIL write_row: got A2=%0h D=%0h, expected A2=%0h D=%0h",
                                 sram_A2, sram_D, e.a, e.d);
                    end
                end
            end
            prev_low = (sram_CEN === 1'b0);
        end else begin
            prev_low = 1'b0;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [127:0] row_d;
        logic [15:0]  w;
        logic [10:0]  r11;
        logic [2:0]   l3;

        reset    = 1'b1;
        in_data  = '0;
        in_valid = 1'b0;
        start    = 1'b0;
        flush    = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_cen", sram_CEN, 1'b1);
        chk("rst_wen", sram_WEN, 1'b1);
        chk("rst_a2", sram_A2, 11'd0);
        chk("rst_d", sram_D, 128'd0);
        chk("rst_rows", rows_written, 12'd0);
        chk("rst_full", full, 1'b0);
        reset = 1'b0;
        #1;
        chk("rst_ready", in_ready, 1'b1);

        // Full row back-to-back
        expect_write(11'd0, 128'h0008_0007_0006_0005_0004_0003_0002_0001);
        push_row(16'h0000);
        chk("t1_ready_in_write", in_ready, 1'b0);
        chk("t1_cen_low", sram_CEN, 1'b0);
        @(posedge clk); #1;
        chk("t1_cen_high", sram_CEN, 1'b1);
        chk("t1_rows", rows_written, 12'd1);

        // Partial row with flush, then an empty flush
        expect_write(11'd1, 128'h0000_0000_0000_0000_0000_CCCC_BBBB_AAAA);
        push_word(16'hAAAA, 1'b0);
        push_word(16'hBBBB, 1'b0);
        push_word(16'hCCCC, 1'b0);
        pulse_flush();
        @(posedge clk); #1;
        pulse_flush();
        @(posedge clk); #1;
        chk("t2_rows", rows_written, 12'd2);

        // Eighth word coincides with flush: single full write
        expect_write(11'd2, 128'h3008_3007_3006_3005_3004_3003_3002_3001);
        for (int i = 1; i <= 7; i++) push_word(16'h3000 + 16'(i), 1'b0);
        push_word(16'h3008, 1'b1);
        repeat (3) @(posedge clk);
        #1;
        chk("t3_rows", rows_written, 12'd3);

        // start discards a partial row and rewinds the pointer
        for (int i = 1; i <= 5; i++) push_word(16'h4000 + 16'(i), 1'b0);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        chk("t5_rows_cleared", rows_written, 12'd0);
        expect_write(11'd0, 128'h5008_5007_5006_5005_5004_5003_5002_5001);
        push_row(16'h5000);
        @(posedge clk); #1;
        chk("t5_rows", rows_written, 12'd1);

        // Asynchronous reset while the strobe is low
        push_row(16'h6000);
        chk("t6_cen_low_before_reset", sram_CEN, 1'b0);
        reset = 1'b1;
        #1;
        chk("t6_cen_async", sram_CEN, 1'b1);
        chk("t6_wen_async", sram_WEN, 1'b1);
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        #1;
        chk("t6_rows", rows_written, 12'd0);
        chk("t6_a2", sram_A2, 11'd0);
        chk("t6_ready", in_ready, 1'b1);
        expect_write(11'd0, 128'h7008_7007_7006_7005_7004_7003_7002_7001);
        push_row(16'h7000);
        @(posedge clk); #1;
        chk("t6_rows_after", rows_written, 12'd1);

        // Fill the whole SRAM
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int r = 0; r < 2048; r++) begin
            r11 = 11'(r);
            for (int l = 0; l < 8; l++) begin
                l3 = 3'(l);
                row_d[l*16 +: 16] = {2'b00, l3, r11};
            end
            expect_write(r11, row_d);
            for (int l = 0; l < 8; l++) begin
                l3 = 3'(l);
                w  = {2'b00, l3, r11};
                push_word(w, 1'b0);
            end
        end
        @(posedge clk); #1;
        chk("t4_rows", rows_written, 12'd2048);
`ifdef PACKER_WRAP_EN
        chk("t4_full_wrap", full, 1'b0);
        chk("t4_ready_wrap", in_ready, 1'b1);
        expect_write(11'd0, 128'h9008_9007_9006_9005_9004_9003_9002_9001);
        push_row(16'h9000);
        @(posedge clk); #1;
        chk("t4_rows_sat", rows_written, 12'd2048);
        chk("t4_full_stays0", full, 1'b0);
`else
        chk("t4_full", full, 1'b1);
        chk("t4_ready_full", in_ready, 1'b0);
        in_valid = 1'b1;
        in_data  = 16'hDEAD;
        flush    = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        in_valid = 1'b0;
        flush    = 1'b0;
        @(posedge clk); #1;
        chk("t4_full_held", full, 1'b1);
        chk("t4_rows_held", rows_written, 12'd2048);
`endif

        repeat (5) @(posedge clk);
        #1;
        chk("queue_drained", 128'(exp_q.size()), 128'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

`default_nettype wire
